// File: rtl/mem_arb_pkg.sv
// Shared constants and FSM state type for the memory data-port arbiter.
package mem_arb_pkg;

    localparam int ADDR_W      = 14;
    localparam int RD_FLAG_BIT = 15;
    localparam int WR_FLAG_BIT = 14;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_e;

endpackage

// File: rtl/mem_port_arbiter_rr_arb2.sv
// Two-input round-robin picker; the last-grant register lives in the parent.
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req_i,
    input  logic       last_grant_i,
    output logic       winner_o,
    output logic       valid_o
);

    always_comb begin
        valid_o  = |req_i;
        winner_o = M0;
        case (req_i)
            2'b01:   winner_o = M0;
            2'b10:   winner_o = M1;
            2'b11:   winner_o = ~last_grant_i;
            default: winner_o = M0;
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing the unified Memory data port between m0 and m1.
// Optional address bounds check enabled by defining MEM_ARB_BOUNDS_CHECK_EN.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int SIZE   = 1024,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m0_err,

    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m1_err,

    output logic [15:0]       mem_dataaddr,
    output logic [DATA_W-1:0] mem_datawrite,
    input  logic [DATA_W-1:0] mem_dataread
);

    localparam logic [31:0] SIZE_U = 32'(SIZE);

    arb_state_e        state_q, state_d;
    logic              last_q, last_d;
    logic              id_q, id_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d;

    logic arb_winner;
    logic arb_valid;
    logic oob;
    logic rd_en;
    logic wr_en;
    logic in_access;
    logic in_resp;

    rr_arb2 u_rr_arb2 (
        .req_i        ({m1_req, m0_req}),
        .last_grant_i (last_q),
        .winner_o     (arb_winner),
        .valid_o      (arb_valid)
    );

`ifdef MEM_ARB_BOUNDS_CHECK_EN
    assign oob = ({{(32-ADDR_W){1'b0}}, addr_q} >= SIZE_U);
`else
    logic unused_size;
    assign unused_size = |SIZE_U;
    assign oob         = 1'b0;
`endif

    assign rd_en     = ~we_q & ~oob;
    assign wr_en     =  we_q & ~oob;
    assign in_access = (state_q == ACCESS);
    assign in_resp   = (state_q == RESP);

    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        id_d     = id_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        case (state_q)
            ACCESS: begin
                state_d = RESP;
                if (rd_en) begin
                    if (id_q == M1) rdata1_d = mem_dataread;
                    else            rdata0_d = mem_dataread;
                end
            end
            IDLE, RESP: begin
                // RESP arbitrates too, giving one access every two cycles.
                if (arb_valid) begin
                    state_d = ACCESS;
                    last_d  = arb_winner;
                    id_d    = arb_winner;
                    we_d    = (arb_winner == M1) ? m1_we    : m0_we;
                    addr_d  = (arb_winner == M1) ? m1_addr  : m0_addr;
                    wdata_d = (arb_winner == M1) ? m1_wdata : m0_wdata;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            last_q   <= M1;
            id_q     <= M0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            id_q     <= id_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    // Memory-side outputs come only from registers, so rst cannot cancel an in-flight write.
    assign mem_dataaddr  = in_access ? {rd_en, wr_en, addr_q} : 16'h0000;
    assign mem_datawrite = (in_access && wr_en) ? wdata_q : '0;

    assign m0_gnt    = in_access && (id_q == M0);
    assign m1_gnt    = in_access && (id_q == M1);
    assign m0_rvalid = in_resp && ~we_q && (id_q == M0);
    assign m1_rvalid = in_resp && ~we_q && (id_q == M1);
    assign m0_rdata  = rdata0_q;
    assign m1_rdata  = rdata1_q;
    assign m0_err    = in_resp && oob && (id_q == M0);
    assign m1_err    = in_resp && oob && (id_q == M1);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed scoreboard bench for mem_port_arbiter with a behavioural Memory model.
module tb_mem_port_arbiter;

`ifdef MEM_ARB_BOUNDS_CHECK_EN
    localparam bit BCHK = 1'b1;
`else
    localparam bit BCHK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        m0_req = 0, m0_we = 0, m1_req = 0, m1_we = 0;
    logic [13:0] m0_addr = 0, m1_addr = 0;
    logic [15:0] m0_wdata = 0, m1_wdata = 0;
    logic        m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
    logic [15:0] m0_rdata, m1_rdata;
    logic [15:0] mem_dataaddr, mem_datawrite, mem_dataread;

    always #5 clk = ~clk;

    mem_port_arbiter #(.SIZE(1024), .DATA_W(16)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_err(m0_err),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_err(m1_err),
        .mem_dataaddr(mem_dataaddr), .mem_datawrite(mem_datawrite),
        .mem_dataread(mem_dataread)
    );

    logic [15:0] mem    [0:16383];
    logic [15:0] shadow [0:16383];
    assign mem_dataread = mem[mem_dataaddr[13:0]];
    always @(posedge clk) if (mem_dataaddr[14]) mem[mem_dataaddr[13:0]] <= mem_datawrite;

    typedef struct { int id; logic [15:0] data; } exp_t;
    exp_t        sb[$];
    int          n_checks = 0;
    int          n_fails  = 0;
    logic [15:0] last_rd [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        chk("flags_exclusive", {31'd0, &mem_dataaddr[15:14]}, 32'd0);
        if (m0_rvalid || m1_rvalid) begin
            if (sb.size() == 0) begin
                chk("unexpected_rvalid", {30'd0, m1_rvalid, m0_rvalid}, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("rvalid_id", {30'd0, m1_rvalid, m0_rvalid}, (e.id == 1) ? 32'd2 : 32'd1);
                chk("rdata", (e.id == 1) ? {16'd0, m1_rdata} : {16'd0, m0_rdata}, {16'd0, e.data});
            end
        end
    end

    task automatic do_cmd(input int m, input logic we, input logic [13:0] addr,
                          input logic [15:0] wd, input int exp_wait, input bit keep);
        int          waited = 0;
        bit          oob;
        logic [15:0] exp_addr;
        oob      = BCHK && (addr >= 14'd1024);
        exp_addr = oob ? {2'b00, addr} : {~we, we, addr};
        if (m == 0) begin m0_we = we; m0_addr = addr; m0_wdata = wd; m0_req = 1'b1; end
        else        begin m1_we = we; m1_addr = addr; m1_wdata = wd; m1_req = 1'b1; end
        if (!we) begin
            if (!oob) last_rd[m] = shadow[addr];
            sb.push_back('{m, last_rd[m]});
        end
        do begin
            @(negedge clk);
            waited++;
        end while (!((m == 0) ? m0_gnt : m1_gnt) && waited < 10);
        chk("gnt_latency", waited, exp_wait);
        chk("dataaddr", {16'd0, mem_dataaddr}, {16'd0, exp_addr});
        chk("datawrite", {16'd0, mem_datawrite}, (we && !oob) ? {16'd0, wd} : 32'd0);
        if (we && !oob) shadow[addr] = wd;
        if (!keep) begin
            if (m == 0) m0_req = 1'b0; else m1_req = 1'b0;
        end
    endtask

    task automatic mem_compare(input string tag);
        int bad = 0;
        for (int i = 0; i < 16384; i++) if (mem[i] !== shadow[i]) bad++;
        chk(tag, bad, 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 16384; i++) begin
            mem[i]    = 16'(i * 3 + 16'h1000);
            shadow[i] = 16'(i * 3 + 16'h1000);
        end
        last_rd[0] = 16'h0;
        last_rd[1] = 16'h0;

        // Both masters hold read requests straight out of reset.
        m0_addr = 14'h020; m1_addr = 14'h030;
        m0_req  = 1'b1;    m1_req  = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_gnt",      {30'd0, m1_gnt, m0_gnt}, 32'd0);
        chk("rst_rvalid",   {30'd0, m1_rvalid, m0_rvalid}, 32'd0);
        chk("rst_err",      {30'd0, m1_err, m0_err}, 32'd0);
        chk("rst_rdata",    {m1_rdata, m0_rdata}, 32'd0);
        chk("rst_dataaddr", {16'd0, mem_dataaddr}, 32'd0);
        chk("rst_datawr",   {16'd0, mem_datawrite}, 32'd0);

        for (int j = 0; j < 4; j++) begin
            last_rd[j % 2] = shadow[(j % 2 == 0) ? 16'h020 : 16'h030];
            sb.push_back('{j % 2, last_rd[j % 2]});
        end
        rst = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            chk("rr_m0_gnt", {31'd0, m0_gnt}, (k % 4 == 1) ? 32'd1 : 32'd0);
            chk("rr_m1_gnt", {31'd0, m1_gnt}, (k % 4 == 3) ? 32'd1 : 32'd0);
            if (k == 8) begin m0_req = 1'b0; m1_req = 1'b0; end
        end
        @(negedge clk);

        // m0 write then read back.
        do_cmd(0, 1'b1, 14'h005, 16'hBEEF, 1, 1'b0);
        @(negedge clk);
        do_cmd(0, 1'b0, 14'h005, 16'h0000, 1, 1'b0);
        @(negedge clk);
        chk("read_latency", {31'd0, m0_rvalid}, 32'd1);

        // m1 alone, back-to-back reads.
        for (int i = 0; i < 4; i++)
            do_cmd(1, 1'b0, 14'(14'h010 + i), 16'h0000, (i == 0) ? 1 : 2, i < 3);
        @(negedge clk);

        // Idle: no stray flags or write data.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("idle_flags",  {30'd0, mem_dataaddr[15:14]}, 32'd0);
            chk("idle_datawr", {16'd0, mem_datawrite}, 32'd0);
        end
        mem_compare("idle_mem_unchanged");

        // Reset during ACCESS of an m1 write: the write still lands.
        m1_we = 1'b1; m1_addr = 14'h0AA; m1_wdata = 16'h1234; m1_req = 1'b1;
        @(negedge clk);
        chk("rstw_gnt", {31'd0, m1_gnt}, 32'd1);
        rst = 1'b1; m1_req = 1'b0;
        shadow[14'h0AA] = 16'h1234;
        last_rd[0] = 16'h0; last_rd[1] = 16'h0;
        @(negedge clk);
        chk("rstw_mem", {16'd0, mem[14'h0AA]}, 32'h1234);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rstw_quiet", {28'd0, m1_gnt, m0_gnt, m1_rvalid, m0_rvalid}, 32'd0);
        end

        // Reset during ACCESS of an m0 read: captured data is discarded.
        m0_we = 1'b0; m0_addr = 14'h020; m0_req = 1'b1;
        @(negedge clk);
        chk("rstr_gnt", {31'd0, m0_gnt}, 32'd1);
        rst = 1'b1; m0_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rstr_quiet", {28'd0, m1_gnt, m0_gnt, m1_rvalid, m0_rvalid}, 32'd0);
            chk("rstr_rdata", {16'd0, m0_rdata}, 32'd0);
        end

        // Bounds: write to 0x400, read from 0x500.
        do_cmd(0, 1'b0, 14'h005, 16'h0000, 1, 1'b0);
        @(negedge clk);
        do_cmd(0, 1'b1, 14'h400, 16'h5555, 1, 1'b0);
        @(negedge clk);
        chk("oobw_err", {30'd0, m1_err, m0_err}, BCHK ? 32'd1 : 32'd0);
        @(negedge clk);
        chk("oobw_err_clear", {30'd0, m1_err, m0_err}, 32'd0);
        do_cmd(0, 1'b0, 14'h500, 16'h0000, 1, 1'b0);
        @(negedge clk);
        chk("oobr_err", {30'd0, m1_err, m0_err}, BCHK ? 32'd1 : 32'd0);
        mem_compare("bounds_mem");

        repeat (3) @(negedge clk);
        chk("sb_drained", sb.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
